// File: rtl/md_pad_reader.sv
// md_pad_reader: host-side Mega Drive pad initiator; drives TH through the 3/6-button
// multiplex sequence and commits registered button states. Option: MD_PAD_DEBOUNCE_EN.
module md_pad_reader #(
    parameter int SETTLE      = 6,
    parameter int POLL_PERIOD = 120000
) (
    input  logic        CLK,
    input  logic        RESET_N,
    input  logic        CE,
    input  logic        ENABLE,
    input  logic        FORCE3,
    input  logic [5:0]  PIN_D,
    output logic        PIN_TH,
    output logic [11:0] BTN,
    output logic        PRESENT,
    output logic        SIX_BTN,
    output logic        VALID
);
    // state  | meaning
    // S_IDLE | TH high, poll timer counts CE ticks towards the next scan
    // S_SCAN | phases 0..7, TH = even phase, sample d after SETTLE ticks
    // S_DONE | one CLK, TH high, commit scratch to outputs and pulse VALID

    localparam int              TW          = (SETTLE > 1) ? $clog2(SETTLE) : 1;
    localparam logic [TW-1:0]   SETTLE_LAST = TW'(SETTLE - 1);
    localparam logic [16:0]     POLL_LAST   = 17'(POLL_PERIOD - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_SCAN,
        S_DONE
    } state_t;

    state_t        state, state_nx;
    logic [2:0]    phase, phase_nx;
    logic [TW-1:0] settle, settle_nx;
    logic [16:0]   poll, poll_nx;
    logic          force3_q, force3_nx;
    logic [11:0]   scr_btn, scr_btn_nx;
    logic          scr_present, scr_present_nx;
    logic          scr_six, scr_six_nx;
    logic          commit;
    logic          th_nx;
    logic [11:0]   btn_new;
    logic [5:0]    d_meta, d_sync;
    logic [5:0]    d;

    // Pad lines are asynchronous to CLK; two flops before any use.
    always_ff @(posedge CLK) begin
        d_meta <= PIN_D;
        d_sync <= d_meta;
    end

    assign d = ~d_sync;

    always_comb begin
        state_nx       = state;
        phase_nx       = phase;
        settle_nx      = settle;
        poll_nx        = poll;
        force3_nx      = force3_q;
        scr_btn_nx     = scr_btn;
        scr_present_nx = scr_present;
        scr_six_nx     = scr_six;
        commit         = 1'b0;

        case (state)
            S_IDLE: begin
                if (CE) begin
                    if (poll == POLL_LAST && ENABLE) begin
                        state_nx       = S_SCAN;
                        phase_nx       = 3'd0;
                        settle_nx      = '0;
                        poll_nx        = '0;
                        force3_nx      = FORCE3;
                        scr_btn_nx     = '0;
                        scr_present_nx = 1'b0;
                        scr_six_nx     = 1'b0;
                    end else begin
                        poll_nx = poll + 17'd1;
                    end
                end
            end
            S_SCAN: begin
                if (CE) begin
                    if (settle == SETTLE_LAST) begin
                        settle_nx = '0;
                        case (phase)
                            3'd0: begin
                                scr_btn_nx[0] = d[0];
                                scr_btn_nx[1] = d[1];
                                scr_btn_nx[2] = d[2];
                                scr_btn_nx[3] = d[3];
                                scr_btn_nx[5] = d[4];
                                scr_btn_nx[6] = d[5];
                            end
                            3'd1: begin
                                scr_btn_nx[4] = d[4];
                                scr_btn_nx[7] = d[5];
                                scr_present_nx = (d[3:2] == 2'b11);
                            end
                            3'd5: scr_six_nx = scr_present & (d[3:0] == 4'b1111);
                            3'd6: begin
                                scr_btn_nx[11] = d[0];
                                scr_btn_nx[10] = d[1];
                                scr_btn_nx[9]  = d[2];
                                scr_btn_nx[8]  = d[3];
                            end
                            default: ;
                        endcase
                        if (phase == 3'd7 || (force3_q && phase == 3'd1))
                            state_nx = S_DONE;
                        else
                            phase_nx = phase + 3'd1;
                    end else begin
                        settle_nx = settle + TW'(1);
                    end
                end
            end
            S_DONE: begin
                commit   = 1'b1;
                state_nx = S_IDLE;
                phase_nx = 3'd0;
                poll_nx  = '0;
            end
            default: begin
                state_nx = S_IDLE;
                phase_nx = 3'd0;
                poll_nx  = '0;
            end
        endcase

        // Disabling aborts immediately and restarts the poll interval from zero.
        if (!ENABLE) begin
            state_nx  = S_IDLE;
            phase_nx  = 3'd0;
            settle_nx = '0;
            poll_nx   = '0;
            commit    = 1'b0;
        end

        th_nx = (state_nx == S_SCAN) ? ~phase_nx[0] : 1'b1;
    end

    always_comb begin
        btn_new = scr_btn;
        if (!scr_present)
            btn_new = '0;
        else if (!scr_six)
            btn_new[11:8] = '0;
    end

`ifdef MD_PAD_DEBOUNCE_EN
    logic [11:0] btn_cmp;
`endif

    always_ff @(posedge CLK) begin
        if (!RESET_N) begin
            state       <= S_IDLE;
            phase       <= 3'd0;
            settle      <= '0;
            poll        <= '0;
            force3_q    <= 1'b0;
            scr_btn     <= '0;
            scr_present <= 1'b0;
            scr_six     <= 1'b0;
            PIN_TH      <= 1'b1;
            BTN         <= '0;
            PRESENT     <= 1'b0;
            SIX_BTN     <= 1'b0;
            VALID       <= 1'b0;
`ifdef MD_PAD_DEBOUNCE_EN
            btn_cmp     <= '0;
`endif
        end else begin
            state       <= state_nx;
            phase       <= phase_nx;
            settle      <= settle_nx;
            poll        <= poll_nx;
            force3_q    <= force3_nx;
            scr_btn     <= scr_btn_nx;
            scr_present <= scr_present_nx;
            scr_six     <= scr_six_nx;
            PIN_TH      <= th_nx;
            VALID       <= commit;
            if (commit) begin
                PRESENT <= scr_present;
                SIX_BTN <= scr_six;
`ifdef MD_PAD_DEBOUNCE_EN
                if (btn_new == btn_cmp)
                    BTN <= btn_new;
                btn_cmp <= btn_new;
`else
                BTN     <= btn_new;
`endif
            end
        end
    end

endmodule

// File: tb/tb_md_pad_reader.sv
// tb_md_pad_reader: directed bench with a behavioural Mega Drive pad and a scan-level
// model of the reader outputs, checked every cycle.
module tb_md_pad_reader;
    localparam int SETTLE = 4;
    localparam int POLL   = 50;

    logic        CLK = 1'b0;
    logic        RESET_N = 1'b0;
    logic        CE = 1'b1;
    logic        ENABLE = 1'b0;
    logic        FORCE3 = 1'b0;
    logic [5:0]  PIN_D;
    logic        PIN_TH;
    logic [11:0] BTN;
    logic        PRESENT;
    logic        SIX_BTN;
    logic        VALID;

    md_pad_reader #(.SETTLE(SETTLE), .POLL_PERIOD(POLL)) dut (
        .CLK(CLK), .RESET_N(RESET_N), .CE(CE), .ENABLE(ENABLE), .FORCE3(FORCE3),
        .PIN_D(PIN_D), .PIN_TH(PIN_TH), .BTN(BTN), .PRESENT(PRESENT),
        .SIX_BTN(SIX_BTN), .VALID(VALID)
    );

    always #5 CLK = ~CLK;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- pad model ----------------
    int          pad_type = 0;          // 0 none, 1 three-button, 2 six-button
    logic [11:0] held = '0;             // {Z,Y,X,MODE,START,C,B,A,RIGHT,LEFT,DOWN,UP}
    int          pad_cnt = 0;
    int          hi_time = 0;
    logic        th_d = 1'b1;
    logic [5:0]  pad_bits;

    always @(posedge CLK) begin
        if (th_d === 1'b1 && PIN_TH === 1'b0)
            pad_cnt <= pad_cnt + 1;
        else if (hi_time >= 40)
            pad_cnt <= 0;
        hi_time <= (PIN_TH === 1'b0) ? 0 : hi_time + 1;
        th_d    <= PIN_TH;
    end

    always_comb begin
        pad_bits = '0;
        if (pad_type != 0) begin
            if (PIN_TH !== 1'b0) begin
                if (pad_type == 2 && pad_cnt == 3)
                    pad_bits = {held[6], held[5], held[8], held[9], held[10], held[11]};
                else
                    pad_bits = {held[6], held[5], held[3], held[2], held[1], held[0]};
            end else begin
                if (pad_type == 2 && pad_cnt == 3)
                    pad_bits = {held[7], held[4], 4'b1111};
                else if (pad_type == 2 && pad_cnt >= 4)
                    pad_bits = {held[7], held[4], 4'b0000};
                else
                    pad_bits = {held[7], held[4], 2'b11, held[1], held[0]};
            end
        end
        PIN_D = ~pad_bits;
    end

    // ---------------- CE generator ----------------
    int ce_mode = 0;
    int ce_ph = 0;
    always @(posedge CLK) begin
        #1;
        if (ce_mode == 0) begin
            CE = 1'b1;
        end else begin
            CE = (ce_ph == 0);
            ce_ph = (ce_ph + 1) % 3;
        end
    end

    // ---------------- scan-level model and per-cycle compare ----------------
    logic        s_rst_n = 1'b0, s_en = 1'b0, s_ce = 1'b1;
    logic        prev_valid = 1'b0, prev_th = 1'b1, clean = 1'b1;
    int          since = 0, falls = 0, n_valid = 0;
    logic [11:0] exp_btn = '0, nb;
    logic        exp_present = 1'b0, exp_six = 1'b0, np, ns;
`ifdef MD_PAD_DEBOUNCE_EN
    logic [11:0] cmp_btn = '0;
`endif

    always @(negedge CLK) begin
        if (!s_rst_n) begin
            exp_btn = '0; exp_present = 1'b0; exp_six = 1'b0;
`ifdef MD_PAD_DEBOUNCE_EN
            cmp_btn = '0;
`endif
            since = 0; clean = 1'b1; falls = 0;
        end else if (!s_en) begin
            since = 0; clean = 1'b1; falls = 0;
        end else begin
            since++;
            if (!s_ce) clean = 1'b0;
            if (prev_th === 1'b1 && PIN_TH === 1'b0) falls++;
        end

        if (!s_rst_n || !s_en) begin
            check("th_idle", PIN_TH, 1);
            check("valid_idle", VALID, 0);
        end

        if (VALID === 1'b1) begin
            n_valid++;
            check("valid_width", prev_valid, 0);
            check("th_at_valid", PIN_TH, 1);
            check("th_falls", falls, FORCE3 ? 1 : 4);
            if (clean)
                check("scan_interval", since, POLL + (FORCE3 ? 2 : 8) * SETTLE + 1);
            np = (pad_type != 0);
            ns = (pad_type == 2) && !FORCE3;
            nb = !np ? 12'h000 : (ns ? held : (held & 12'h0FF));
`ifdef MD_PAD_DEBOUNCE_EN
            if (nb == cmp_btn) exp_btn = nb;
            cmp_btn = nb;
`else
            exp_btn = nb;
`endif
            exp_present = np;
            exp_six = ns;
            since = 0; clean = 1'b1; falls = 0;
        end

        check("btn", BTN, exp_btn);
        check("present", PRESENT, exp_present);
        check("six_btn", SIX_BTN, exp_six);

        prev_valid = VALID;
        prev_th    = PIN_TH;
        s_rst_n    = RESET_N;
        s_en       = ENABLE;
        s_ce       = CE;
    end

    // ---------------- stimulus ----------------
    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic wait_valid();
        int k;
        k = 0;
        while (VALID !== 1'b1 && k < 800) begin
            tick();
            k++;
        end
        check("wait_valid", VALID, 1);
        tick();
    endtask

    task automatic wait_falls(input int n);
        int k, f;
        logic last;
        k = 0; f = 0; last = PIN_TH;
        while (f < n && k < 800) begin
            tick();
            k++;
            if (last === 1'b1 && PIN_TH === 1'b0) f++;
            last = PIN_TH;
        end
        check("wait_falls", f, n);
    endtask

    task automatic scan_trace(output logic [15:0] seq, output int n);
        int k;
        logic last;
        k = 0; seq = '0; n = 0; last = PIN_TH;
        while (VALID !== 1'b1 && k < 800) begin
            tick();
            k++;
            if (PIN_TH !== last) begin
                seq = {seq[14:0], PIN_TH};
                n++;
                last = PIN_TH;
            end
        end
        check("trace_valid", VALID, 1);
        tick();
    endtask

    logic [15:0] seq;
    int          nchg;
    int          v0;

    initial begin
        RESET_N = 1'b0;
        ENABLE  = 1'b1;
        repeat (3) tick();
        check("rst_th", PIN_TH, 1);
        check("rst_btn", BTN, 12'h000);
        check("rst_present", PRESENT, 0);
        check("rst_valid", VALID, 0);
        RESET_N = 1'b1;

        // six-button pad, UP+A+Z
        pad_type = 2; held = 12'h811;
        wait_valid();
        scan_trace(seq, nchg);
        check("t1_th_changes", nchg, 8);
        check("t1_th_seq", seq[7:0], 8'b0101_0101);
        check("t1_btn", BTN, 12'h811);
        check("t1_present", PRESENT, 1);
        check("t1_six", SIX_BTN, 1);

        // three-button pad, START+C, slow CE
        ce_mode = 1; pad_type = 1; held = 12'h0C0;
        wait_valid(); wait_valid();
        check("t2_btn", BTN, 12'h0C0);
        check("t2_btn_hi", BTN[11:8], 4'h0);
        check("t2_present", PRESENT, 1);
        check("t2_six", SIX_BTN, 0);

        // no pad: pull-ups only
        ce_mode = 0; pad_type = 0; held = 12'hFFF;
        wait_valid(); wait_valid();
        v0 = n_valid;
        wait_valid();
        check("t3_valid_count", n_valid, v0 + 1);
        check("t3_btn", BTN, 12'h000);
        check("t3_present", PRESENT, 0);
        check("t3_six", SIX_BTN, 0);

        // FORCE3 with six-button pad, X held
        pad_type = 2; held = 12'h200; FORCE3 = 1'b1;
        wait_valid();
        scan_trace(seq, nchg);
        check("t4_th_changes", nchg, 2);
        check("t4_th_seq", seq[1:0], 2'b01);
        check("t4_btn", BTN, 12'h000);
        check("t4_present", PRESENT, 1);
        check("t4_six", SIX_BTN, 0);

        // ENABLE drop in phase 3, then mid-scan reset
        FORCE3 = 1'b0; held = 12'h001;
        wait_valid(); wait_valid();
        check("t5_btn_before", BTN, 12'h001);
        wait_falls(2);
        tick();
        v0 = n_valid;
        ENABLE = 1'b0;
        tick();
        check("t5_th_abort", PIN_TH, 1);
        repeat (5) tick();
        check("t5_no_valid", n_valid, v0);
        check("t5_btn_held", BTN, 12'h001);
        ENABLE = 1'b1;
        wait_valid();
        check("t5_btn_after", BTN, 12'h001);
        wait_falls(1);
        tick();
        RESET_N = 1'b0;
        tick();
        check("t5_rst_btn", BTN, 12'h000);
        check("t5_rst_present", PRESENT, 0);
        check("t5_rst_six", SIX_BTN, 0);
        check("t5_rst_th", PIN_TH, 1);
        check("t5_rst_valid", VALID, 0);
        RESET_N = 1'b1;
        wait_valid(); wait_valid();
        check("t5_btn_recover", BTN, 12'h001);

        // single-scan B press
        held = 12'h000;
        wait_valid(); wait_valid();
        held = 12'h020;
        wait_valid();
`ifdef MD_PAD_DEBOUNCE_EN
        check("t6_glitch", BTN, 12'h000);
        held = 12'h000;
        wait_valid();
        check("t6_glitch_gone", BTN, 12'h000);
        held = 12'h020;
        wait_valid(); wait_valid();
        check("t6_stable", BTN, 12'h020);
`else
        check("t6_direct", BTN, 12'h020);
        held = 12'h000;
        wait_valid();
        check("t6_release", BTN, 12'h000);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #3000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
